systolic_array_ws: RTL and testbench
====================================

Name: systolic_array_ws

Overview:
- Parametrised weight-stationary systolic matrix-vector engine. Successor to the fixed 3x3 array.
- Holds a ROWS x COLS weight matrix W in the processing elements (PEs). Each accepted activation vector a[0..ROWS-1] produces out[c] = sum over r of a[r]*W[r][c], for c = 0..COLS-1.
- Adds runtime weight loading, valid/ready handshakes, internal input skew and output de-skew, and a load/compute/drain FSM.
- Sits between the activation buffer and the accumulator/writeback stage.

Parameters:
- ROWS, 3, reduction depth (PE rows, activation vector length)
- COLS, 3, output channels (PE columns)
- DATA_W, 32, signed width of activations and weights
- ACC_W, 32, signed width of partial sums and outputs

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- wload_start  in  1  request to (re)load weights
- wload_valid  in  1  weight row beat valid
- wload_ready  out  1  array accepts weight beats
- wload_data  in  COLS*DATA_W  one weight row, W[r][c] at slice c
- in_valid  in  1  activation vector valid
- in_ready  out  1  array accepts activation vectors
- in_data  in  ROWS*DATA_W  a[r] at slice r
- out_valid  out  1  result vector valid, one-cycle pulse per vector
- out_data  out  COLS*ACC_W  out[c] at slice c
- busy  out  1  state != IDLE or results still in flight

Behaviour:
- Reset (sync, rst=1 at posedge):
  - All weights cleared to 0; state set to IDLE.
  - Skew and de-skew pipelines and their valid bits cleared; in-flight counter = 0.
  - out_valid=0, out_data=0, wload_ready=0, in_ready=0, busy=0.
  - Reset mid-load or mid-compute discards all work; no out_valid follows.
- FSM states: IDLE, LOAD, COMPUTE, DRAIN.
  - IDLE: wload_start -> LOAD, row counter = 0. in_valid is ignored.
  - LOAD: wload_ready=1. Each wload_valid beat writes row[row counter] and increments it. After beat ROWS-1 -> COMPUTE. wload_start in LOAD restarts at row 0.
  - COMPUTE: in_ready=1. Each in_valid&&in_ready cycle injects one vector; one vector per cycle is allowed (full throughput). wload_start -> DRAIN; a vector presented in the same cycle as wload_start is still accepted.
  - DRAIN: in_ready=0, wload_ready=0. When the in-flight counter reaches 0 -> LOAD. Weights used by in-flight vectors are never modified before the counter reaches 0.
- Dataflow:
  - Activation a[r] is delayed r cycles by the skew registers, then moves horizontally through row r (one register per PE).
  - Partial sums move vertically down column c (one register per PE), starting from 0 at row 0.
  - Column c output is delayed (COLS-1-c) cycles by de-skew registers so all channels align.
- Latency: out_valid asserts exactly ROWS+COLS cycles after the accepting edge. Order is preserved. Back-to-back inputs give back-to-back outputs.
- Arithmetic:
  - Operands signed. Each product is sign-extended or truncated to ACC_W.
  - Accumulation is two's-complement, wrapping modulo 2^ACC_W, with no saturation.
- In-flight counter: +1 on accept, -1 on out_valid, unchanged when both occur in the same cycle.
- out_data holds its last value when out_valid=0.
- busy = (state!=IDLE) || (counter!=0).
- wload_valid outside LOAD is ignored. wload_start during DRAIN is ignored.

Test Plan:
- Reset then load: rst pulse; wload_start, then 3 beats with rows {1,1,1},{2,2,2},{3,3,3} -> wload_ready high exactly 3 cycles, then in_ready=1. Single in {1,2,3} -> out_valid exactly 6 cycles after accept, out_data={14,14,14}.
- Throughput: inputs {1,0,0},{0,1,0},{0,0,1},{2,2,2} on 4 consecutive cycles -> 4 consecutive out_valid pulses, {1,1,1},{2,2,2},{3,3,3},{12,12,12}, in that order.
- Reload with drain: 2 vectors in flight and wload_start asserted -> in_ready drops, both old-weight results appear. LOAD is entered only after the last out_valid. New weights all 5 with in {1,1,1} -> {15,15,15}.
- Signed/wrap: weight -1 everywhere, in {-2,3,0x7FFFFFFF} -> each out = -(1+0x7FFFFFFF) mod 2^32 = 0x80000000.
- Reset mid-operation: rst one cycle after 2 accepts -> no out_valid afterwards, out_data=0, state IDLE, and in_valid is ignored until a reload.
- Parameter sweep: ROWS=4, COLS=2, DATA_W=8, ACC_W=20 -> random vectors match a reference model at latency 6, with a random in_valid duty cycle.

Source files
------------

// File: rtl/systolic_array_ws.sv
// Weight-stationary systolic matrix-vector engine: ROWS x COLS PEs hold W,
// each accepted vector a yields out[c] = sum_r a[r]*W[r][c], ROWS+COLS cycles later.

module systolic_pe #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     w_we,
  input  logic signed [DATA_W-1:0] w_d,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [ACC_W-1:0]  p_n,
  output logic signed [ACC_W-1:0]  p_s
);
  logic signed [DATA_W-1:0] w_q;
  logic signed [ACC_W-1:0]  a_x, w_x;

  // Product taken modulo 2^ACC_W: operands sign-extended or truncated first.
  assign a_x = ACC_W'(a);
  assign w_x = ACC_W'(w_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      w_q <= '0;
      p_s <= '0;
    end else begin
      if (w_we) w_q <= w_d;
      p_s <= p_n + a_x * w_x;
    end
  end
endmodule

module systolic_array_ws #(
  parameter int ROWS   = 3,
  parameter int COLS   = 3,
  parameter int DATA_W = 32,
  parameter int ACC_W  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wload_start,
  input  logic                   wload_valid,
  output logic                   wload_ready,
  input  logic [COLS*DATA_W-1:0] wload_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ROWS*DATA_W-1:0] in_data,
  output logic                   out_valid,
  output logic [COLS*ACC_W-1:0]  out_data,
  output logic                   busy
);
  localparam int STAGES = ROWS + COLS;
  localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW     = $clog2(STAGES + 2);

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} state_t;

  state_t                              state;
  logic [RW-1:0]                       row_cnt;
  logic [CW-1:0]                       inflight;
  logic                                accept, w_wr;
  logic [STAGES:0]                     vld_pipe;
  logic [ROWS-1:0][DATA_W-1:0]         a_acc;
  logic [ROWS-1:0][COLS-1:0][DATA_W-1:0] pe_a;
  logic [ROWS:0][COLS-1:0][ACC_W-1:0]  ps;
  logic [COLS-1:0][ACC_W-1:0]          col_res;

  assign accept    = in_valid && in_ready;
  assign w_wr      = (state == LOAD) && wload_valid && !wload_start;
  assign out_valid = vld_pipe[STAGES];
  assign busy      = (state != IDLE) || (inflight != '0);
  assign a_acc     = accept ? in_data : '0;
  assign ps[0]     = '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      row_cnt     <= '0;
      wload_ready <= 1'b0;
      in_ready    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (wload_start) begin
          state       <= LOAD;
          row_cnt     <= '0;
          wload_ready <= 1'b1;
        end
        LOAD: begin
          if (wload_start) row_cnt <= '0;
          else if (wload_valid) begin
            if (row_cnt == RW'(ROWS - 1)) begin
              state       <= COMPUTE;
              wload_ready <= 1'b0;
              in_ready    <= 1'b1;
            end else begin
              row_cnt <= row_cnt + 1'b1;
            end
          end
        end
        COMPUTE: if (wload_start) begin
          state    <= DRAIN;
          in_ready <= 1'b0;
        end
        DRAIN: if (inflight == '0) begin
          state       <= LOAD;
          row_cnt     <= '0;
          wload_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
      vld_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], accept};
      if (accept && !out_valid)      inflight <= inflight + 1'b1;
      else if (!accept && out_valid) inflight <= inflight - 1'b1;
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [DATA_W-1:0] src;

    // Row r sees its activation r cycles late so wavefronts meet the psums.
    if (r == 0) begin : g_direct
      assign src = a_acc[0];
    end else begin : g_skew
      logic [r-1:0][DATA_W-1:0] sk;
      always_ff @(posedge clk) begin
        if (rst) sk <= '0;
        else begin
          for (int k = r - 1; k > 0; k--) sk[k] <= sk[k-1];
          sk[0] <= a_acc[r];
        end
      end
      assign src = sk[r-1];
    end

    always_ff @(posedge clk) begin
      if (rst) pe_a[r] <= '0;
      else begin
        for (int c = COLS - 1; c > 0; c--) pe_a[r][c] <= pe_a[r][c-1];
        pe_a[r][0] <= src;
      end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_col
      systolic_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
        .clk  (clk),
        .rst  (rst),
        .w_we (w_wr && (row_cnt == RW'(r))),
        .w_d  (wload_data[c*DATA_W +: DATA_W]),
        .a    (pe_a[r][c]),
        .p_n  (ps[r][c]),
        .p_s  (ps[r+1][c])
      );
    end
  end

  // Early columns finish first; delay them so all channels leave together.
  for (genvar c = 0; c < COLS; c++) begin : g_deskew
    localparam int D = COLS - 1 - c;
    if (D == 0) begin : g_pass
      assign col_res[c] = ps[ROWS][c];
    end else begin : g_dly
      logic [D-1:0][ACC_W-1:0] ds;
      always_ff @(posedge clk) begin
        if (rst) ds <= '0;
        else begin
          for (int k = D - 1; k > 0; k--) ds[k] <= ds[k-1];
          ds[0] <= ps[ROWS][c];
        end
      end
      assign col_res[c] = ds[D-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) out_data <= '0;
    else if (vld_pipe[STAGES-1]) out_data <= col_res;
  end
endmodule

// File: tb/tb_systolic_array_ws.sv
// Directed bench for systolic_array_ws: default 3x3 instance plus a 4x2 narrow instance.

module tb_systolic_array_ws;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, wload_start = 1'b0, wload_valid = 1'b0, in_valid = 1'b0;
  logic        wload_ready, in_ready, out_valid, busy;
  logic [95:0] wload_data = '0, in_data = '0, out_data;

  logic        b_rst = 1'b1, b_wload_start = 1'b0, b_wload_valid = 1'b0, b_in_valid = 1'b0;
  logic        b_wload_ready, b_in_ready, b_out_valid, b_busy;
  logic [15:0] b_wload_data = '0;
  logic [31:0] b_in_data = '0;
  logic [39:0] b_out_data;

  int n_checks = 0, n_fail = 0;
  logic [95:0] vecs [8];
  logic [95:0] cap_data [$];
  int          cap_cyc  [$];

  systolic_array_ws dut (
    .clk(clk), .rst(rst), .wload_start(wload_start), .wload_valid(wload_valid),
    .wload_ready(wload_ready), .wload_data(wload_data), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
    .out_data(out_data), .busy(busy)
  );

  systolic_array_ws #(.ROWS(4), .COLS(2), .DATA_W(8), .ACC_W(20)) dut_b (
    .clk(clk), .rst(b_rst), .wload_start(b_wload_start), .wload_valid(b_wload_valid),
    .wload_ready(b_wload_ready), .wload_data(b_wload_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .in_data(b_in_data), .out_valid(b_out_valid),
    .out_data(b_out_data), .busy(b_busy)
  );

  function automatic logic [95:0] p3(input logic [31:0] x0, x1, x2);
    return {x2, x1, x0};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  // Drives n vectors on consecutive cycles and records every output with its cycle index.
  task automatic run(input int n, input int ncyc);
    cap_data.delete();
    cap_cyc.delete();
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      if (out_valid) begin
        cap_data.push_back(out_data);
        cap_cyc.push_back(cyc);
      end
      if (cyc < n) begin
        in_valid = 1'b1;
        in_data  = vecs[cyc];
      end else begin
        in_valid = 1'b0;
        in_data  = '0;
      end
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic beats(input logic [95:0] row, input int n);
    for (int i = 0; i < n; i++) begin
      wload_valid = 1'b1;
      wload_data  = row;
      step();
    end
    wload_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
    n_checks++; if (wload_ready !== 1'b0) begin n_fail++; $display("FAIL reset_wload_ready: got %b want 0", wload_ready); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (out_data !== 96'd0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_load_single();
    int wr_hi = 0;
    logic [95:0] rows [3];
    rows[0] = p3(1, 1, 1); rows[1] = p3(2, 2, 2); rows[2] = p3(3, 3, 3);
    wload_start = 1'b1;
    step();
    wload_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (wload_ready) wr_hi++;
      wload_valid = 1'b1;
      wload_data  = rows[i];
      step();
    end
    wload_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (wload_ready) wr_hi++;
      step();
    end
    n_checks++; if (wr_hi != 3) begin n_fail++; $display("FAIL load_ready_cycles: got %0d want 3", wr_hi); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL load_in_ready: got %b want 1", in_ready); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL load_busy: got %b want 1", busy); end

    vecs[0] = p3(1, 2, 3);
    run(1, 12);
    n_checks++; if (cap_data.size() != 1) begin n_fail++; $display("FAIL single_count: got %0d want 1", cap_data.size()); end
    if (cap_data.size() >= 1) begin
      n_checks++; if (cap_cyc[0] != 7) begin n_fail++; $display("FAIL single_latency: got %0d want 6", cap_cyc[0] - 1); end
      n_checks++; if (cap_data[0] !== p3(14, 14, 14)) begin n_fail++; $display("FAIL single_data: got %h want %h", cap_data[0], p3(14, 14, 14)); end
    end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_pulse: got %b want 0", out_valid); end
    n_checks++; if (out_data !== p3(14, 14, 14)) begin n_fail++; $display("FAIL hold_data: got %h want %h", out_data, p3(14, 14, 14)); end
  endtask

  task automatic test_back_to_back();
    logic [95:0] exp [4];
    vecs[0] = p3(1, 0, 0); vecs[1] = p3(0, 1, 0); vecs[2] = p3(0, 0, 1); vecs[3] = p3(2, 2, 2);
    exp[0]  = p3(1, 1, 1); exp[1]  = p3(2, 2, 2); exp[2]  = p3(3, 3, 3); exp[3]  = p3(12, 12, 12);
    run(4, 14);
    n_checks++; if (cap_data.size() != 4) begin n_fail++; $display("FAIL b2b_count: got %0d want 4", cap_data.size()); end
    for (int i = 0; i < 4 && i < cap_data.size(); i++) begin
      n_checks++; if (cap_cyc[i] != 7 + i) begin n_fail++; $display("FAIL b2b_cycle%0d: got %0d want %0d", i, cap_cyc[i], 7 + i); end
      n_checks++; if (cap_data[i] !== exp[i]) begin n_fail++; $display("FAIL b2b_data%0d: got %h want %h", i, cap_data[i], exp[i]); end
    end
  endtask

  task automatic test_reload_drain();
    int last_ov = -1, first_wr = -1;
    cap_data.delete();
    in_valid = 1'b1; in_data = p3(1, 1, 1);
    step();
    in_data = p3(1, 0, 0); wload_start = 1'b1;
    step();
    in_valid = 1'b0; wload_start = 1'b0;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL drain_in_ready: got %b want 0", in_ready); end
    // Stray beats and a stray start during drain must not disturb the old weights.
    wload_valid = 1'b1; wload_data = p3(9, 9, 9);
    for (int cyc = 2; cyc < 40; cyc++) begin
      if (out_valid) begin
        cap_data.push_back(out_data);
        last_ov = cyc;
      end
      if (wload_ready) begin
        first_wr = cyc;
        break;
      end
      wload_start = (cyc == 4);
      step();
    end
    wload_start = 1'b0; wload_valid = 1'b0;
    n_checks++; if (cap_data.size() != 2) begin n_fail++; $display("FAIL drain_count: got %0d want 2", cap_data.size()); end
    if (cap_data.size() >= 2) begin
      n_checks++; if (cap_data[0] !== p3(6, 6, 6)) begin n_fail++; $display("FAIL drain_data0: got %h want %h", cap_data[0], p3(6, 6, 6)); end
      n_checks++; if (cap_data[1] !== p3(1, 1, 1)) begin n_fail++; $display("FAIL drain_data1: got %h want %h", cap_data[1], p3(1, 1, 1)); end
    end
    n_checks++; if (last_ov != 8) begin n_fail++; $display("FAIL drain_last_out: got %0d want 8", last_ov); end
    n_checks++; if (first_wr != 10) begin n_fail++; $display("FAIL drain_load_entry: got %0d want 10", first_wr); end

    beats(p3(5, 5, 5), 3);
    vecs[0] = p3(1, 1, 1);
    run(1, 12);
    n_checks++; if (cap_data.size() != 1 || cap_data[0] !== p3(15, 15, 15)) begin
      n_fail++; $display("FAIL reload_data: got %h (n=%0d) want %h", out_data, cap_data.size(), p3(15, 15, 15));
    end
  endtask

  task automatic test_signed_wrap();
    int waited = 0;
    wload_start = 1'b1;
    step();
    wload_start = 1'b0;
    while (!wload_ready && waited < 10) begin
      step();
      waited++;
    end
    n_checks++; if (wload_ready !== 1'b1) begin n_fail++; $display("FAIL wrap_load_wait: got %b want 1", wload_ready); end
    beats(p3(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 3);
    vecs[0] = p3(32'hFFFF_FFFE, 32'd3, 32'h7FFF_FFFF);
    run(1, 12);
    n_checks++; if (cap_data.size() != 1 || cap_data[0] !== p3(32'h8000_0000, 32'h8000_0000, 32'h8000_0000)) begin
      n_fail++; $display("FAIL wrap_data: got %h (n=%0d) want 800000008000000080000000", out_data, cap_data.size());
    end
  endtask

  task automatic test_reset_mid();
    int ov = 0, ir = 0;
    in_valid = 1'b1; in_data = p3(1, 2, 3);
    step();
    in_data = p3(4, 5, 6);
    step();
    in_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid) ov++;
      if (in_ready) ir++;
      in_valid = 1'b1; in_data = p3(1, 1, 1);
      step();
    end
    in_valid = 1'b0;
    n_checks++; if (ov != 0) begin n_fail++; $display("FAIL rstmid_out_valid: got %0d pulses want 0", ov); end
    n_checks++; if (ir != 0) begin n_fail++; $display("FAIL rstmid_in_ready: got %0d cycles want 0", ir); end
    n_checks++; if (out_data !== 96'd0) begin n_fail++; $display("FAIL rstmid_out_data: got %h want 0", out_data); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    n_checks++; if (wload_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_wload_ready: got %b want 0", wload_ready); end
  endtask

  task automatic test_sweep();
    int wv [4][2];
    logic [39:0] exp_q [$];
    int exp_c [$];
    logic [15:0] row;
    logic [39:0] exp, got_d;
    int got = 0, acc, av, ec;
    logic v;
    b_rst = 1'b1;
    step(); step();
    b_rst = 1'b0;
    step();
    n_checks++; if (b_busy !== 1'b0 || b_out_valid !== 1'b0) begin n_fail++; $display("FAIL sweep_reset: got busy=%b ov=%b want 0 0", b_busy, b_out_valid); end
    b_wload_start = 1'b1;
    step();
    b_wload_start = 1'b0;
    n_checks++; if (b_wload_ready !== 1'b1) begin n_fail++; $display("FAIL sweep_wload_ready: got %b want 1", b_wload_ready); end
    for (int r = 0; r < 4; r++) begin
      row = 16'($urandom);
      for (int c = 0; c < 2; c++) wv[r][c] = $signed(row[c*8 +: 8]);
      b_wload_valid = 1'b1; b_wload_data = row;
      step();
    end
    b_wload_valid = 1'b0;
    n_checks++; if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL sweep_in_ready: got %b want 1", b_in_ready); end
    for (int cyc = 0; cyc < 70; cyc++) begin
      if (b_out_valid) begin
        got++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL sweep_extra: got %h at cycle %0d want none", b_out_data, cyc);
        end else begin
          got_d = b_out_data;
          exp = exp_q.pop_front();
          ec  = exp_c.pop_front();
          if (got_d !== exp) begin n_fail++; $display("FAIL sweep_data: got %h want %h", got_d, exp); end
          n_checks++; if (cyc != ec) begin n_fail++; $display("FAIL sweep_latency: got cycle %0d want %0d", cyc, ec); end
        end
      end
      v = (cyc < 50) && ($urandom_range(0, 99) < 60);
      b_in_valid = v;
      b_in_data  = $urandom;
      if (v && b_in_ready) begin
        for (int c = 0; c < 2; c++) begin
          acc = 0;
          for (int r = 0; r < 4; r++) begin
            av = $signed(b_in_data[r*8 +: 8]);
            acc += av * wv[r][c];
          end
          exp[c*20 +: 20] = acc[19:0];
        end
        exp_q.push_back(exp);
        exp_c.push_back(cyc + 7);
      end
      step();
    end
    b_in_valid = 1'b0;
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL sweep_missing: got %0d outstanding want 0", exp_q.size()); end
    n_checks++; if (got < 10) begin n_fail++; $display("FAIL sweep_results: got %0d want at least 10", got); end
  endtask

  initial begin
    step();
    test_reset();
    test_load_single();
    test_back_to_back();
    test_reload_drain();
    test_signed_wrap();
    test_reset_mid();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
